// File: rtl/i2c_rht_target.sv
// I2C target emulating an RH/temperature sensor. 16-bit registers sit behind
// a pointer byte; writing pointer 0x00 starts a timed measurement.
module i2c_rht_target #(
  parameter logic [6:0]  I2C_ADDR    = 7'h40,
  parameter int          MEAS_CYCLES = 320000,
  parameter logic [15:0] CFG_RESET   = 16'h1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] temp_in,
  input  logic [15:0] hum_in,
  output logic        drdy_n,
  output logic        busy,
  output logic [15:0] config_out
);
  localparam int CW = $clog2(MEAS_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_e;

  function automatic logic [15:0] reg_rd(
    input logic [7:0]  a,
    input logic [15:0] t,
    input logic [15:0] h,
    input logic [15:0] c
  );
    case (a)
      8'h00:   reg_rd = t;
      8'h01:   reg_rd = h;
      8'h02:   reg_rd = c;
      default: reg_rd = 16'h0000;
    endcase
  endfunction

  // [0],[1] synchronizer, [2] history
  logic [2:0]    scl_q, scl_d, sda_q, sda_d;
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          oe_q, oe_d;
  logic          rw_q, rw_d;
  logic [7:0]    ptr_q, ptr_d;
  logic          hi_q, hi_d;
  logic [7:0]    wbuf_q, wbuf_d;
  logic [15:0]   word_q, word_d;
  logic [7:0]    tx_q, tx_d;
  logic [15:0]   cfg_q, cfg_d;
  logic [15:0]   temp_q, temp_d;
  logic [15:0]   hum_q, hum_d;
  logic          busy_q, busy_d;
  logic          drdy_q, drdy_d;
  logic [CW-1:0] mcnt_q, mcnt_d;

  logic        scl_rise, scl_fall, sda_rise, sda_fall;
  logic        start, stop, addr_hit;
  logic [7:0]  ptr_inc;
  logic [15:0] rd_cur, rd_nxt;

  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign sda_rise = sda_q[1] & ~sda_q[2];
  assign sda_fall = ~sda_q[1] & sda_q[2];
  assign start    = scl_q[1] & sda_fall;
  assign stop     = scl_q[1] & sda_rise;
  assign addr_hit = (sr_q[7:1] == I2C_ADDR);
  assign ptr_inc  = ptr_q + 8'd1;
  assign rd_cur   = reg_rd(ptr_q, temp_q, hum_q, cfg_q);
  assign rd_nxt   = reg_rd(ptr_inc, temp_q, hum_q, cfg_q);

  always_comb begin
    scl_d   = {scl_q[1:0], scl_i};
    sda_d   = {sda_q[1:0], sda_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    oe_d    = oe_q;
    rw_d    = rw_q;
    ptr_d   = ptr_q;
    hi_d    = hi_q;
    wbuf_d  = wbuf_q;
    word_d  = word_q;
    tx_d    = tx_q;
    cfg_d   = cfg_q;
    temp_d  = temp_q;
    hum_d   = hum_q;
    busy_d  = busy_q;
    drdy_d  = drdy_q;
    mcnt_d  = mcnt_q;

    if (busy_q) begin
      mcnt_d = mcnt_q - CW'(1);
      if (mcnt_q == CW'(1)) begin
        temp_d = temp_in;
        hum_d  = hum_in;
        busy_d = 1'b0;
        drdy_d = 1'b0;
      end
    end

    if (stop) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end else if (start) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else begin
      if (scl_rise) begin
        sr_d  = {sr_q[6:0], sda_q[1]};
        cnt_d = cnt_q + 4'd1;
      end
      if (scl_fall) begin
        case (state_q)
          ADDR: if (cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            rw_d  = sr_q[0];
            if (addr_hit) drdy_d = 1'b1;
            if (addr_hit && !(sr_q[0] && busy_q)) begin
              state_d = ADDR_ACK;
              oe_d    = 1'b1;
            end else begin
              state_d = IGNORE;
              oe_d    = 1'b0;
            end
          end
          ADDR_ACK: begin
            cnt_d = 4'd0;
            if (rw_q) begin
              state_d = RDATA;
              word_d  = rd_cur;
              tx_d    = rd_cur[15:8];
              hi_d    = 1'b1;
              oe_d    = ~rd_cur[15];
            end else begin
              state_d = PTR;
              oe_d    = 1'b0;
            end
          end
          PTR: if (cnt_q == 4'd8) begin
            cnt_d   = 4'd0;
            ptr_d   = sr_q;
            state_d = PTR_ACK;
            oe_d    = 1'b1;
            if (sr_q == 8'h00) begin
              mcnt_d = CW'(MEAS_CYCLES);
              busy_d = 1'b1;
              drdy_d = 1'b1;
            end
          end
          PTR_ACK, WDATA_ACK: begin
            cnt_d   = 4'd0;
            state_d = WDATA;
            oe_d    = 1'b0;
            if (state_q == PTR_ACK) hi_d = 1'b0;
          end
          WDATA: if (cnt_q == 4'd8) begin
            cnt_d   = 4'd0;
            state_d = WDATA_ACK;
            oe_d    = 1'b1;
            if (!hi_q) begin
              wbuf_d = sr_q;
              hi_d   = 1'b1;
            end else begin
              if (ptr_q == 8'h02) cfg_d = {wbuf_q, sr_q};
              ptr_d = ptr_inc;
              hi_d  = 1'b0;
            end
          end
          RDATA: begin
            if (cnt_q == 4'd8) begin
              cnt_d   = 4'd0;
              state_d = RDATA_ACK;
              oe_d    = 1'b0;
            end else begin
              oe_d = ~tx_q[3'd7 - cnt_q[2:0]];
            end
          end
          RDATA_ACK: begin
            cnt_d = 4'd0;
            // sr_q[0] holds the master's acknowledge bit
            if (sr_q[0]) begin
              state_d = IGNORE;
              oe_d    = 1'b0;
            end else if (hi_q) begin
              state_d = RDATA;
              tx_d    = word_q[7:0];
              hi_d    = 1'b0;
              oe_d    = ~word_q[7];
            end else begin
              state_d = RDATA;
              ptr_d   = ptr_inc;
              word_d  = rd_nxt;
              tx_d    = rd_nxt[15:8];
              hi_d    = 1'b1;
              oe_d    = ~rd_nxt[15];
            end
          end
          default: oe_d = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_q   <= '1;
      sda_q   <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      oe_q    <= 1'b0;
      rw_q    <= 1'b0;
      ptr_q   <= '0;
      hi_q    <= 1'b0;
      wbuf_q  <= '0;
      word_q  <= '0;
      tx_q    <= '0;
      cfg_q   <= CFG_RESET;
      temp_q  <= '0;
      hum_q   <= '0;
      busy_q  <= 1'b0;
      drdy_q  <= 1'b1;
      mcnt_q  <= '0;
    end else begin
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      oe_q    <= oe_d;
      rw_q    <= rw_d;
      ptr_q   <= ptr_d;
      hi_q    <= hi_d;
      wbuf_q  <= wbuf_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      cfg_q   <= cfg_d;
      temp_q  <= temp_d;
      hum_q   <= hum_d;
      busy_q  <= busy_d;
      drdy_q  <= drdy_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign sda_oe     = oe_q;
  assign drdy_n     = drdy_q;
  assign busy       = busy_q;
  assign config_out = cfg_q;
endmodule
